// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared widths, state encoding and port ids for the RAM port arbiter
package ram_port_arbiter_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_A = 2'd1,
        XFER_B = 2'd2,
        DONE   = 2'd3
    } state_t;
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;
endpackage

// File: rtl/ram_port_arbiter_starve_cnt.sv
// ram_port_arbiter_starve_cnt: saturating count of port B's lost arbitrations
//   clk, reset_n : clock, async active-low reset
//   inc          : A won while B was requesting
//   clr          : B won
//   starved      : count has reached LIMIT
module ram_port_arbiter_starve_cnt
    import ram_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic starved
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end
    assign starved = cnt >= CNT_W'(LIMIT);
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between CPU port A (priority) and aux port B
//   clk, reset_n                         : clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata -> a_ack   : port A request, ack pulses one cycle when done
//   b_req/b_we/b_addr/b_wdata -> b_ack   : port B, same protocol
//   rdata                                : registered read data, valid in the read's ack cycle
//   ram_addr/ram_wdata/ram_rd/ram_wr     : RAM pins, zero outside a transfer
//   ram_rdata                            : combinational RAM read data
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_rdata
);
    state_t state, state_nx;
    port_t  last, last_nx;
    logic   arb, a_cand, b_cand, a_wins, b_wins, starved, xa, xb, we;

    ram_port_arbiter_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (a_wins & b_req),
        .clr     (b_wins),
        .starved (starved)
    );

    // In DONE the port being acked must not win again straight away.
    always_comb begin
        arb      = state == IDLE || state == DONE;
        a_cand   = a_req && !(state == DONE && last == PORT_A);
        b_cand   = b_req && !(state == DONE && last == PORT_B);
        b_wins   = arb && b_cand && (starved || !a_cand);
        a_wins   = arb && a_cand && !b_wins;
        state_nx = b_wins ? XFER_B : a_wins ? XFER_A : arb ? IDLE : DONE;
        last_nx  = b_wins ? PORT_B : a_wins ? PORT_A : last;
        xa       = state == XFER_A;
        xb       = state == XFER_B;
        we       = xa ? a_we : xb & b_we;
        ram_addr  = xa ? a_addr : xb ? b_addr : '0;
        ram_wdata = xa ? a_wdata : xb ? b_wdata : '0;
        ram_wr    = we;
        ram_rd    = (xa | xb) & ~we;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= PORT_A;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            a_ack <= xa;
            b_ack <= xb;
            if (ram_rd)
                rdata <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random traffic checked against a transaction-level model
module tb_ram_port_arbiter;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LIM = 4;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, b_ack, ram_rd, ram_wr;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] ram     [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};

    int vectors = 0, miscompares = 0;
    int cur = -1, acked = -1, starve = 0;
    int a_issued = 0, a_done = 0, b_issued = 0, b_done = 0, nb = 0;
    logic [DW-1:0] exp_rdata = '0;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_wr) ram[ram_addr] <= ram_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One arbitration or one transfer completion per clock edge.
    task automatic model_edge();
        logic [AW-1:0] ad;
        logic          w;
        logic [DW-1:0] wd;
        bit            a_c, b_c;
        int            win;
        if (cur >= 0) begin
            ad = cur == 0 ? a_addr : b_addr;
            w  = cur == 0 ? a_we : b_we;
            wd = cur == 0 ? a_wdata : b_wdata;
            if (w) ref_mem[ad] = wd;
            else exp_rdata = ref_mem[ad];
            acked = cur;
            cur = -1;
        end else begin
            a_c = a_req && acked != 0;
            b_c = b_req && acked != 1;
            win = (b_c && (starve >= LIM || !a_c)) ? 1 : a_c ? 0 : -1;
            if (win == 0 && b_req) starve = starve < 15 ? starve + 1 : 15;
            if (win == 1) starve = 0;
            cur = win;
            acked = -1;
        end
    endtask

    task automatic check_all();
        logic w;
        w = cur == 0 ? a_we : b_we;
        chk("a_ack", a_ack, acked == 0);
        chk("b_ack", b_ack, acked == 1);
        chk("rdata", rdata, exp_rdata);
        chk("ram_wr", ram_wr, cur >= 0 && w);
        chk("ram_rd", ram_rd, cur >= 0 && !w);
        chk("ram_addr", ram_addr, cur == 0 ? a_addr : cur == 1 ? b_addr : '0);
        chk("rd_wr_excl", ram_rd & ram_wr, 0);
        chk("ack_excl", a_ack & b_ack, 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic requesters(input bit allow);
        if (a_ack) begin
            chk("a_once", a_req, 1);
            a_done++;
            a_req = 0;
        end else if (!a_req && allow && $urandom_range(0, 2) == 0) begin
            a_req = 1; a_we = 1'($urandom_range(0, 1));
            a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
            a_issued++;
        end
        if (b_ack) begin
            chk("b_once", b_req, 1);
            b_done++;
            b_req = 0;
        end else if (!b_req && allow && $urandom_range(0, 2) == 0) begin
            b_req = 1; b_we = 1'($urandom_range(0, 1));
            b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
            b_issued++;
        end
    endtask

    initial begin
        #2;
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_ram_wr", ram_wr, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        repeat (3) tick();

        a_req = 1; a_we = 1; a_addr = 12'h005; a_wdata = 16'hBEEF;
        tick();
        chk("t2_wr_early", a_ack, 0);
        tick();
        chk("t2_wr_ack", a_ack, 1);
        a_req = 0;
        tick();
        a_req = 1; a_we = 0;
        tick();
        tick();
        chk("t2_rd_ack", a_ack, 1);
        chk("t2_rdata", rdata, 16'hBEEF);
        a_req = 0;
        tick();

        a_req = 1; a_we = 1; a_addr = 12'h010; a_wdata = 16'h1111;
        b_req = 1; b_we = 1; b_addr = 12'h020; b_wdata = 16'h2222;
        tick();
        tick();
        chk("t3_a_first", a_ack, 1);
        chk("t3_b_waits", b_ack, 0);
        a_req = 0;
        tick();
        chk("t3_b_gap", b_ack, 0);
        tick();
        chk("t3_b_ack", b_ack, 1);
        b_req = 0;
        tick();

        a_req = 1; a_we = 0; a_addr = 12'h005;
        b_we = 0; b_addr = 12'h010;
        for (int i = 0; i < 16; i++) begin
            if (b_ack) begin b_req = 0; nb++; end
            else b_req = 1;
            tick();
        end
        chk("t4_b_served", nb > 0, 1);
        a_req = 0;
        b_req = 0;
        tick();
        tick();

        b_req = 1; b_we = 1; b_addr = 12'h0FF; b_wdata = 16'h1234;
        tick();
        chk("t5_in_xfer", ram_wr, 1);
        #2;
        reset_n = 0;
        #1;
        chk("t5_wr_cut", ram_wr, 0);
        chk("t5_no_ack", b_ack, 0);
        cur = -1; acked = -1; starve = 0; exp_rdata = '0;
        b_req = 0;
        @(posedge clk); #1;
        chk("t5_no_ack_later", b_ack, 0);
        chk("t5_ram_wr_low", ram_wr, 0);
        reset_n = 1;
        tick();
        b_req = 1; b_we = 0;
        tick();
        tick();
        chk("t5_rd_ack", b_ack, 1);
        chk("t5_write_lost", rdata, 0);
        b_req = 0;
        tick();

        for (int i = 0; i < 400; i++) begin
            requesters(1);
            tick();
        end
        for (int i = 0; i < 20 && (a_req || b_req || a_ack || b_ack); i++) begin
            requesters(0);
            tick();
        end
        chk("drained", a_req | b_req, 0);
        chk("a_all_acked", a_done, a_issued);
        chk("b_all_acked", b_done, b_issued);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
